banked_reg_file: RTL and testbench
==================================

# banked_reg_file

Parametrised ARMv4 register file: 16 architectural registers mapped onto 31 physical registers with per-mode banking (FIQ R8–R14; IRQ/SVC/ABT/UND R13–R14). Sits between the instruction register, the ALU result bus and the A/B/C operand buses, replacing the flat 16-entry bank. It adds a load/store-multiple (LSM) register-list sequencer that steps through the register list one register per advance.

## Interface
- DATA_W, 32, register and bus width
- PC_RESET, 32'h3000, reset value of R15
- PC_STEP, 4, PC auto-increment amount
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- IR  input  32  instruction; Rn=IR[19:16], Rd=IR[15:12], Rs=IR[11:8], Rm=IR[3:0]
- MODE  input  5  CPSR mode: 10000 USR, 10001 FIQ, 10010 IRQ, 10011 SVC, 10111 ABT, 11011 UND, 11111 SYS; any other value maps to the user bank
- ALU_BUS  input  DATA_W  write data
- LATCH_REG  input  1  write ALU_BUS to the selected Rd this edge
- PC_INC  input  1  add PC_STEP to R15 this edge
- IR_RD_MUX  input  1  1: Rd=IR[15:12]; 0: Rd=IR[19:16] (multiply layout)
- LSM_RD_MUX  input  1  1: Rd and Rm index come from LSM_REG
- REG_GATE_B, REG_GATE_C  input  1  drive B_BUS / C_BUS
- LSM_START  input  1  load LSM_LIST and begin sequencing
- LSM_LIST  input  16  register list, bit i = Ri
- LSM_ADV  input  1  current list register consumed
- LSM_USER  input  1  LSM-indexed accesses use the user bank (S bit)
- A_BUS  output  DATA_W  reg[Rn], always driven
- B_BUS  output  DATA_W  reg[Rm] when REG_GATE_B, else high-Z
- C_BUS  output  DATA_W  reg[Rs] when REG_GATE_C, else high-Z
- PC  output  DATA_W  R15
- ST  output  DATA_W  R12 of the active bank
- LSM_REG  output  4  index of the current list register
- LSM_BUSY  output  1  sequencer active
- LSM_DONE  output  1  one-cycle pulse on completion

## Operation
- Banking: R0–R7 and R15 are shared. R8–R12 are split into FIQ and non-FIQ copies. R13–R14 have six copies: USR/SYS, FIQ, IRQ, SVC, ABT, UND. The same mapping applies to reads and writes. When LSM_USER=1, the LSM-sourced index uses the USR mapping.
- Reads are combinational from current state, with no +8 PC offset. A read in the same cycle as a write to that register returns the pre-edge value.
- Write: if LATCH_REG=1, phys(Rd) <= ALU_BUS.
- If PC_INC=1, R15 <= R15 + PC_STEP, modulo 2^DATA_W.
- If LATCH_REG=1 with Rd=15 and PC_INC=1 in the same cycle, the ALU write wins.
- LSM sequencer states:
  - IDLE: on LSM_START, if LSM_LIST≠0, latch the list into an internal mask and go to RUN. If LSM_LIST=0, pulse LSM_DONE next cycle and stay IDLE.
  - RUN: LSM_REG = lowest set bit of the mask; LSM_BUSY=1. On LSM_ADV, clear that bit. If it was the last bit, go to IDLE and pulse LSM_DONE. LSM_START in RUN is ignored.
- MODE changes mid-LSM take effect immediately on subsequent accesses.

## Timing
- Reset values: all general registers 0, R15=PC_RESET, sequencer IDLE. After reset: A_BUS=0 for Rn≠15, PC=PC_RESET, ST=0, LSM_REG=0, LSM_BUSY=0, LSM_DONE=0. B_BUS/C_BUS follow their gates.
- rst has priority over every write, increment and sequencer action; reset mid-LSM aborts with no DONE pulse.
- Write latency: register updated at edge N and visible on the buses after edge N, in the same cycle.
- LSM_START at edge N: BUSY=1 and LSM_REG valid after edge N. Each LSM_ADV edge advances by one list entry. For k set bits with ADV held high, BUSY lasts exactly k cycles and DONE asserts in the cycle after the last ADV.
- In RUN, an LSM_ADV edge and a LATCH_REG edge with LSM_RD_MUX=1 in the same cycle write the current LSM_REG, then advance.

## Test plan
- **Reset and PC increment:** assert rst, then PC_INC=1 for two cycles.
  - Expect PC=0x3000, then 0x3008.
  - Expect B_BUS=Z with REG_GATE_B=0.
- **Banking:**
  - MODE=USR: write R13=0x1111. MODE=SVC: write R13=0x2222. MODE=FIQ: write R8=0xAAAA.
  - Back in USR: read R13 → 0x1111, R8 → 0.
  - In SVC: R13 → 0x2222.
  - In SYS: R13 → 0x1111.
- **PC collision:** LATCH_REG=1, Rd=15, ALU_BUS=0x4000, PC_INC=1 → PC=0x4000.
- **Multiply layout:** IR=0x000E2007, IR_RD_MUX=0, ALU_BUS=24 → R14 of the active bank = 24. A_BUS=R2, B_BUS=R7 before the edge.
- **LSM sequencing:** LSM_LIST=0x8021, ADV held high.
  - Expect LSM_REG sequence 0, 5, 15; BUSY for 3 cycles; one DONE pulse.
  - LSM_START during RUN is ignored.
- **LSM edge cases:**
  - LSM_LIST=0 → DONE pulse, BUSY never asserts.
  - rst mid-LSM → BUSY=0 next cycle, no DONE pulse.
  - LSM_USER=1 in FIQ writing R8 → user R8 updated, FIQ R8 unchanged.

Source files
------------

// File: rtl/banked_reg_file_if.sv
// Operand/control bundle between the decode stage and the banked register file.
// The tri-stated B/C buses stay outside this bundle as plain ports of the register file.
interface banked_reg_file_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       IR;
    logic [4:0]        MODE;
    logic [DATA_W-1:0] ALU_BUS;
    logic              LATCH_REG;
    logic              PC_INC;
    logic              IR_RD_MUX;
    logic              LSM_RD_MUX;
    logic              REG_GATE_B;
    logic              REG_GATE_C;
    logic              LSM_START;
    logic [15:0]       LSM_LIST;
    logic              LSM_ADV;
    logic              LSM_USER;
    logic [DATA_W-1:0] A_BUS;
    logic [DATA_W-1:0] PC;
    logic [DATA_W-1:0] ST;
    logic [3:0]        LSM_REG;
    logic              LSM_BUSY;
    logic              LSM_DONE;

    modport master (
        output IR, MODE, ALU_BUS, LATCH_REG, PC_INC, IR_RD_MUX, LSM_RD_MUX,
               REG_GATE_B, REG_GATE_C, LSM_START, LSM_LIST, LSM_ADV, LSM_USER,
        input  A_BUS, PC, ST, LSM_REG, LSM_BUSY, LSM_DONE
    );

    modport slave (
        input  IR, MODE, ALU_BUS, LATCH_REG, PC_INC, IR_RD_MUX, LSM_RD_MUX,
               REG_GATE_B, REG_GATE_C, LSM_START, LSM_LIST, LSM_ADV, LSM_USER,
        output A_BUS, PC, ST, LSM_REG, LSM_BUSY, LSM_DONE
    );
endinterface

// File: rtl/banked_reg_file.sv
// ARMv4 register file: 16 architectural registers over 31 physical slots with
// per-mode banking, plus a load/store-multiple register-list sequencer.
module banked_reg_file #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] PC_RESET = 'h3000,
    parameter int                PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    banked_reg_file_if.slave   bus,
    output wire  [DATA_W-1:0]  B_BUS,
    output wire  [DATA_W-1:0]  C_BUS
);
    localparam int NPHYS = 31;

    // Physical layout: 0-15 user/shared, 16-22 FIQ R8-R14, then R13/R14 pairs
    // for IRQ (23), SVC (25), ABT (27), UND (29).
    function automatic logic [4:0] phys_idx(input logic [3:0] r, input logic [4:0] mode,
                                            input logic user);
        logic       sp_lr;
        logic [4:0] off;
        sp_lr    = (r == 4'd13) || (r == 4'd14);
        off      = {4'b0, r == 4'd14};
        phys_idx = {1'b0, r};
        if (!user) begin
            case (mode)
                5'b10001: if (r >= 4'd8 && r <= 4'd14) phys_idx = {1'b0, r} + 5'd8;
                5'b10010: if (sp_lr) phys_idx = 5'd23 + off;
                5'b10011: if (sp_lr) phys_idx = 5'd25 + off;
                5'b10111: if (sp_lr) phys_idx = 5'd27 + off;
                5'b11011: if (sp_lr) phys_idx = 5'd29 + off;
                default:  phys_idx = {1'b0, r};
            endcase
        end
    endfunction

    typedef enum logic {IDLE, RUN} lsm_state_t;

    logic [DATA_W-1:0] regs [NPHYS];
    lsm_state_t        state, state_next;
    logic [15:0]       mask, mask_next, mask_cleared;
    logic              done, done_next;
    logic [3:0]        cur;

    logic [3:0] rn, rd, rm, rs;
    logic       lsm_user_eff;
    logic [4:0] rn_phys, rd_phys, rm_phys, rs_phys, st_phys;
    logic       unused_ir;

    assign unused_ir = ^{bus.IR[31:20], bus.IR[7:4]};

    // Multiply layout swaps the roles of IR[19:16] and IR[15:12].
    assign rn           = bus.IR_RD_MUX ? bus.IR[19:16] : bus.IR[15:12];
    assign rd           = bus.LSM_RD_MUX ? cur : (bus.IR_RD_MUX ? bus.IR[15:12] : bus.IR[19:16]);
    assign rm           = bus.LSM_RD_MUX ? cur : bus.IR[3:0];
    assign rs           = bus.IR[11:8];
    assign lsm_user_eff = bus.LSM_RD_MUX & bus.LSM_USER;

    assign rn_phys = phys_idx(rn, bus.MODE, 1'b0);
    assign rd_phys = phys_idx(rd, bus.MODE, lsm_user_eff);
    assign rm_phys = phys_idx(rm, bus.MODE, lsm_user_eff);
    assign rs_phys = phys_idx(rs, bus.MODE, 1'b0);
    assign st_phys = phys_idx(4'd12, bus.MODE, 1'b0);

    assign bus.A_BUS = regs[rn_phys];
    assign bus.PC    = regs[15];
    assign bus.ST    = regs[st_phys];
    assign B_BUS     = bus.REG_GATE_B ? regs[rm_phys] : 'z;
    assign C_BUS     = bus.REG_GATE_C ? regs[rs_phys] : 'z;

    // ALU write is issued after the increment so it wins a collision on R15.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NPHYS; i++) begin
                regs[i] <= (i == 15) ? PC_RESET : '0;
            end
        end else begin
            if (bus.PC_INC) begin
                regs[15] <= regs[15] + DATA_W'(PC_STEP);
            end
            if (bus.LATCH_REG) begin
                regs[rd_phys] <= bus.ALU_BUS;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mask  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            mask  <= mask_next;
            done  <= done_next;
        end
    end

    // Mask is empty in IDLE, so cur (and LSM_REG) reads 0 there.
    always_comb begin
        cur = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) cur = 4'(i);
        end
    end

    assign mask_cleared = mask & ~(16'd1 << cur);

    always_comb begin
        state_next = state;
        mask_next  = mask;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.LSM_START) begin
                    if (|bus.LSM_LIST) begin
                        mask_next  = bus.LSM_LIST;
                        state_next = RUN;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.LSM_ADV) begin
                    mask_next = mask_cleared;
                    if (mask_cleared == 16'd0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.LSM_REG  = cur;
    assign bus.LSM_BUSY = (state == RUN);
    assign bus.LSM_DONE = done;
endmodule

// File: tb/tb_banked_reg_file.sv
// Directed bench for banked_reg_file: bank-level reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_banked_reg_file;
    localparam logic [4:0] USR = 5'b10000, FIQ = 5'b10001, SVC = 5'b10011, SYS = 5'b11111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    wire  [31:0] b_bus, c_bus;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          started  = 1'b0;

    banked_reg_file_if #(.DATA_W(32)) bus ();

    banked_reg_file #(.DATA_W(32), .PC_RESET(32'h3000), .PC_STEP(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .B_BUS (b_bus),
        .C_BUS (c_bus)
    );

    always #5 clk = ~clk;

    // Reference state organised by bank rather than by physical slot.
    logic [31:0] m_gen  [0:15];
    logic [31:0] m_fiq  [8:14];
    logic [31:0] m_bank [0:3][13:14];
    int          m_q[$];
    bit          m_done;

    function automatic int mode_kind(input logic [4:0] mode);
        case (mode)
            5'b10001: return 1;
            5'b10010: return 2;
            5'b10011: return 3;
            5'b10111: return 4;
            5'b11011: return 5;
            default:  return 0;
        endcase
    endfunction

    function automatic logic [31:0] mread(input logic [3:0] r, input logic [4:0] mode, input bit user);
        int k;
        k = user ? 0 : mode_kind(mode);
        if (k == 1 && r >= 8 && r <= 14) return m_fiq[r];
        if (k >= 2 && (r == 13 || r == 14)) return m_bank[k-2][r];
        return m_gen[r];
    endfunction

    task automatic mwrite(input logic [3:0] r, input logic [4:0] mode, input bit user,
                          input logic [31:0] val);
        int k;
        k = user ? 0 : mode_kind(mode);
        if (k == 1 && r >= 8 && r <= 14) m_fiq[r] = val;
        else if (k >= 2 && (r == 13 || r == 14)) m_bank[k-2][r] = val;
        else m_gen[r] = val;
    endtask

    function automatic logic [3:0] m_cur();
        return (m_q.size() != 0) ? 4'(m_q[0]) : 4'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_ne(input string name, input logic [31:0] act, input logic [31:0] bad);
        n_checks++;
        if (act === bad) begin
            n_fail++;
            $display("FAIL %s: got %h, must not carry register value %h", name, act, bad);
        end
    endtask

    always @(posedge clk) begin
        logic [3:0] wr;
        bit         busy;
        started = 1'b1;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_gen[i] = 32'h0;
            m_gen[15] = 32'h3000;
            for (int i = 8; i <= 14; i++) m_fiq[i] = 32'h0;
            for (int b = 0; b < 4; b++) begin
                m_bank[b][13] = 32'h0;
                m_bank[b][14] = 32'h0;
            end
            m_q.delete();
            m_done = 1'b0;
        end else begin
            busy = (m_q.size() != 0);
            wr   = bus.LSM_RD_MUX ? m_cur() : (bus.IR_RD_MUX ? bus.IR[15:12] : bus.IR[19:16]);
            if (bus.PC_INC) m_gen[15] = m_gen[15] + 32'd4;
            if (bus.LATCH_REG) mwrite(wr, bus.MODE, bus.LSM_RD_MUX & bus.LSM_USER, bus.ALU_BUS);
            m_done = 1'b0;
            if (!busy) begin
                if (bus.LSM_START) begin
                    if (bus.LSM_LIST == 16'h0) m_done = 1'b1;
                    else for (int i = 0; i < 16; i++) if (bus.LSM_LIST[i]) m_q.push_back(i);
                end
            end else if (bus.LSM_ADV) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0]  rn, rm;
        logic [31:0] bv, cv;
        if (started) begin
            rn = bus.IR_RD_MUX ? bus.IR[19:16] : bus.IR[15:12];
            rm = bus.LSM_RD_MUX ? m_cur() : bus.IR[3:0];
            bv = mread(rm, bus.MODE, bus.LSM_RD_MUX & bus.LSM_USER);
            cv = mread(bus.IR[11:8], bus.MODE, 1'b0);
            check("model A_BUS", bus.A_BUS, mread(rn, bus.MODE, 1'b0));
            check("model PC", bus.PC, m_gen[15]);
            check("model ST", bus.ST, mread(4'd12, bus.MODE, 1'b0));
            check("model LSM_REG", {28'h0, bus.LSM_REG}, {28'h0, m_cur()});
            check("model LSM_BUSY", {31'h0, bus.LSM_BUSY}, {31'h0, m_q.size() != 0});
            check("model LSM_DONE", {31'h0, bus.LSM_DONE}, {31'h0, m_done});
            if (bus.REG_GATE_B) check("model B_BUS", b_bus, bv);
            else if (bv != 32'h0) check_ne("model B_BUS off", b_bus, bv);
            if (bus.REG_GATE_C) check("model C_BUS", c_bus, cv);
            else if (cv != 32'h0) check_ne("model C_BUS off", c_bus, cv);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] mode, input logic [3:0] r, input logic [31:0] val);
        bus.MODE      = mode;
        bus.IR        = {16'h0, r, 12'h0};
        bus.IR_RD_MUX = 1'b1;
        bus.ALU_BUS   = val;
        bus.LATCH_REG = 1'b1;
        tick();
        bus.LATCH_REG = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [4:0] mode, input logic [3:0] r,
                            input logic [31:0] exp);
        bus.MODE      = mode;
        bus.IR_RD_MUX = 1'b1;
        bus.IR        = {12'h0, r, 16'h0};
        settle();
        check(name, bus.A_BUS, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.IR = 32'h0; bus.MODE = USR; bus.ALU_BUS = 32'h0;
        bus.LATCH_REG = 1'b0; bus.PC_INC = 1'b0; bus.IR_RD_MUX = 1'b0; bus.LSM_RD_MUX = 1'b0;
        bus.REG_GATE_B = 1'b0; bus.REG_GATE_C = 1'b0; bus.LSM_START = 1'b0;
        bus.LSM_LIST = 16'h0; bus.LSM_ADV = 1'b0; bus.LSM_USER = 1'b0;

        tick(); tick();
        rst = 1'b0;
        check("reset PC", bus.PC, 32'h3000);
        check("reset A_BUS", bus.A_BUS, 32'h0);
        check("reset ST", bus.ST, 32'h0);
        check("reset LSM_REG", {28'h0, bus.LSM_REG}, 32'h0);
        check("reset LSM_BUSY", {31'h0, bus.LSM_BUSY}, 32'h0);
        check("reset LSM_DONE", {31'h0, bus.LSM_DONE}, 32'h0);

        bus.IR = 32'h0000_0F0F;
        settle();
        check_ne("B_BUS gated off", b_bus, 32'h3000);
        bus.REG_GATE_B = 1'b1; bus.REG_GATE_C = 1'b1;
        settle();
        check("B_BUS R15", b_bus, 32'h3000);
        check("C_BUS R15", c_bus, 32'h3000);
        bus.REG_GATE_B = 1'b0; bus.REG_GATE_C = 1'b0;

        bus.PC_INC = 1'b1;
        tick(); tick();
        bus.PC_INC = 1'b0;
        check("PC after two incs", bus.PC, 32'h3008);

        wr(USR, 4'd13, 32'h1111);
        wr(SVC, 4'd13, 32'h2222);
        wr(FIQ, 4'd8,  32'hAAAA);
        wr(FIQ, 4'd12, 32'h005A);
        rd_check("USR R13", USR, 4'd13, 32'h1111);
        rd_check("USR R8", USR, 4'd8, 32'h0);
        check("USR ST", bus.ST, 32'h0);
        rd_check("SVC R13", SVC, 4'd13, 32'h2222);
        rd_check("SYS R13", SYS, 4'd13, 32'h1111);
        rd_check("FIQ R8", FIQ, 4'd8, 32'hAAAA);
        check("FIQ ST", bus.ST, 32'h005A);

        bus.MODE = USR; bus.IR = 32'h0000_F000; bus.IR_RD_MUX = 1'b1;
        bus.ALU_BUS = 32'h4000; bus.LATCH_REG = 1'b1; bus.PC_INC = 1'b1;
        tick();
        bus.LATCH_REG = 1'b0; bus.PC_INC = 1'b0;
        check("PC collision", bus.PC, 32'h4000);

        wr(USR, 4'd2, 32'h22);
        wr(USR, 4'd7, 32'h77);
        bus.IR = 32'h000E_2007; bus.IR_RD_MUX = 1'b0; bus.REG_GATE_B = 1'b1;
        bus.ALU_BUS = 32'd24; bus.LATCH_REG = 1'b1;
        settle();
        check("mul A_BUS=R2", bus.A_BUS, 32'h22);
        check("mul B_BUS=R7", b_bus, 32'h77);
        tick();
        bus.LATCH_REG = 1'b0; bus.REG_GATE_B = 1'b0;
        rd_check("mul R14", USR, 4'd14, 32'd24);

        bus.LSM_LIST = 16'h8021; bus.LSM_START = 1'b1;
        tick();
        check("lsm busy 1", {31'h0, bus.LSM_BUSY}, 32'h1);
        check("lsm reg 0", {28'h0, bus.LSM_REG}, 32'd0);
        bus.LSM_LIST = 16'h0002; bus.LSM_ADV = 1'b1;
        tick();
        bus.LSM_START = 1'b0;
        check("lsm reg 5", {28'h0, bus.LSM_REG}, 32'd5);
        check("lsm busy 2", {31'h0, bus.LSM_BUSY}, 32'h1);
        tick();
        check("lsm reg 15", {28'h0, bus.LSM_REG}, 32'd15);
        check("lsm busy 3", {31'h0, bus.LSM_BUSY}, 32'h1);
        tick();
        bus.LSM_ADV = 1'b0;
        check("lsm busy end", {31'h0, bus.LSM_BUSY}, 32'h0);
        check("lsm done pulse", {31'h0, bus.LSM_DONE}, 32'h1);
        tick();
        check("lsm done clears", {31'h0, bus.LSM_DONE}, 32'h0);
        check("lsm stays idle", {31'h0, bus.LSM_BUSY}, 32'h0);

        bus.LSM_LIST = 16'h0; bus.LSM_START = 1'b1;
        tick();
        bus.LSM_START = 1'b0;
        check("empty list done", {31'h0, bus.LSM_DONE}, 32'h1);
        check("empty list busy", {31'h0, bus.LSM_BUSY}, 32'h0);
        tick();
        check("empty list done clears", {31'h0, bus.LSM_DONE}, 32'h0);

        bus.MODE = FIQ; bus.LSM_LIST = 16'h0100; bus.LSM_START = 1'b1;
        tick();
        bus.LSM_START = 1'b0;
        check("lsm user reg 8", {28'h0, bus.LSM_REG}, 32'd8);
        bus.LSM_RD_MUX = 1'b1; bus.LSM_USER = 1'b1; bus.REG_GATE_B = 1'b1;
        bus.ALU_BUS = 32'hBEEF; bus.LATCH_REG = 1'b1; bus.LSM_ADV = 1'b1;
        settle();
        check("lsm user B_BUS pre-edge", b_bus, 32'h0);
        tick();
        bus.LSM_RD_MUX = 1'b0; bus.LSM_USER = 1'b0; bus.REG_GATE_B = 1'b0;
        bus.LATCH_REG = 1'b0; bus.LSM_ADV = 1'b0;
        check("lsm user done", {31'h0, bus.LSM_DONE}, 32'h1);
        rd_check("FIQ R8 kept", FIQ, 4'd8, 32'hAAAA);
        rd_check("user R8 written", USR, 4'd8, 32'hBEEF);

        bus.LSM_LIST = 16'h00F0; bus.LSM_START = 1'b1;
        tick();
        bus.LSM_START = 1'b0; bus.LSM_ADV = 1'b1;
        tick();
        check("mid-lsm reg 5", {28'h0, bus.LSM_REG}, 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.LSM_ADV = 1'b0;
        check("rst abort busy", {31'h0, bus.LSM_BUSY}, 32'h0);
        check("rst abort done", {31'h0, bus.LSM_DONE}, 32'h0);
        check("rst abort PC", bus.PC, 32'h3000);
        tick();
        check("rst abort no late done", {31'h0, bus.LSM_DONE}, 32'h0);
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
